// File: rtl/riscv_pkg.sv
// Shared types and encodings for the memory stage: LSU states, funct3 access
// codes, result-source selects, and small helpers for access size/alignment.
package riscv_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Any funct3 that is not a byte or halfword form behaves as a word access.
    function automatic logic [1:0] accessSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: accessSize = SZ_BYTE;
            F3_H, F3_HU: accessSize = SZ_HALF;
            default:     accessSize = SZ_WORD;
        endcase
    endfunction

    // Bytes are always aligned; halfwords need an even address; words need
    // both low address bits clear.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: isMisaligned = 1'b0;
            SZ_HALF: isMisaligned = offset[0];
            default: isMisaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to the load's funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rawData,
    input  logic [1:0]  byteOff,
    input  logic [2:0]  funct3,
    output logic [31:0] readData
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        shifted = rawData >> {byteOff, 3'b000};
        case (funct3)
            F3_B:    readData = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   readData = {24'b0, shifted[7:0]};
            F3_H:    readData = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   readData = {16'b0, shifted[15:0]};
            default: readData = rawData;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: runs one data-bus transaction per EX/MEM
// entry over a req/grant/rvalid bus, stalls the pipeline during wait states,
// and owns the MEM/WB pipeline register.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [3:0]  DBe,
    output logic [31:0] DWData,
    input  logic        DGnt,
    input  logic        DRValid,
    input  logic [31:0] DRData,
    output logic        StallM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignW,
    output logic        BusErrW
);

    // The wait counter only ever needs to reach TIMEOUT-1; the abort fires on
    // the cycle that would be the TIMEOUT-th one spent in REQ/RESP.
    localparam int              CNT_W      = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic            TIMEOUT_EN = (TIMEOUT != 0);

    lsu_state_t       state;
    lsu_state_t       stateNext;
    logic [CNT_W-1:0] waitCnt;

    logic [1:0]  accSize;
    logic        isStore;
    logic        isLoad;
    logic        isAccess;
    logic        misaligned;
    logic        goodAccess;
    logic        timeoutHit;
    logic        reqRaw;
    logic        stallRaw;
    logic        complete;
    logic        timedOut;
    logic        clearCnt;
    logic        incCnt;
    logic [31:0] alignedData;

    assign isStore    = MemWriteM;
    assign isLoad     = ~MemWriteM & (ResultSrcM == RES_LOAD);
    assign isAccess   = isStore | isLoad;
    assign accSize    = accessSize(Funct3M);
    assign misaligned = isAccess & isMisaligned(accSize, ALUResultM[1:0]);
    assign goodAccess = isAccess & ~misaligned;
    assign timeoutHit = TIMEOUT_EN & (waitCnt == LAST_WAIT);

    // Bus request and stall are forced low while reset is held so the
    // pipeline and bus see a quiet unit regardless of the EX/MEM contents.
    assign DReq   = reqRaw & reset;
    assign StallM = stallRaw & reset;
    assign DWe    = DReq & MemWriteM;
    assign DAddr  = {ALUResultM[31:2], 2'b00};

    load_align u_load_align (
        .rawData (DRData),
        .byteOff (ALUResultM[1:0]),
        .funct3  (Funct3M),
        .readData(alignedData)
    );

    // Byte enables follow the access size and offset; store data is
    // replicated across all lanes so the memory can pick any of them.
    always_comb begin
        DBe    = 4'b1111;
        DWData = WriteDataM;
        case (accSize)
            SZ_BYTE: begin
                DBe    = 4'b0001 << ALUResultM[1:0];
                DWData = {4{WriteDataM[7:0]}};
            end
            SZ_HALF: begin
                DBe    = 4'b0011 << ALUResultM[1:0];
                DWData = {2{WriteDataM[15:0]}};
            end
            default: begin
                DBe    = 4'b1111;
                DWData = WriteDataM;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LSU_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, bus request, stall, and MEM/WB capture decisions.
    always_comb begin
        stateNext = state;
        reqRaw    = 1'b0;
        stallRaw  = 1'b0;
        complete  = 1'b0;
        timedOut  = 1'b0;
        clearCnt  = 1'b0;
        incCnt    = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (goodAccess) begin
                    reqRaw = 1'b1;
                    if (DGnt) begin
                        if (isStore) begin
                            complete = 1'b1;
                        end else begin
                            stateNext = LSU_RESP;
                            stallRaw  = 1'b1;
                            clearCnt  = 1'b1;
                        end
                    end else begin
                        stateNext = LSU_REQ;
                        stallRaw  = 1'b1;
                        clearCnt  = 1'b1;
                    end
                end else begin
                    complete = 1'b1;
                end
            end
            LSU_REQ: begin
                reqRaw = 1'b1;
                if (DGnt) begin
                    if (isStore) begin
                        complete  = 1'b1;
                        stateNext = LSU_IDLE;
                    end else begin
                        stateNext = LSU_RESP;
                        stallRaw  = 1'b1;
                        clearCnt  = 1'b1;
                    end
                end else if (timeoutHit) begin
                    timedOut  = 1'b1;
                    stateNext = LSU_IDLE;
                end else begin
                    stallRaw = 1'b1;
                    incCnt   = 1'b1;
                end
            end
            LSU_RESP: begin
                if (DRValid) begin
                    complete  = 1'b1;
                    stateNext = LSU_IDLE;
                end else if (timeoutHit) begin
                    timedOut  = 1'b1;
                    stateNext = LSU_IDLE;
                end else begin
                    stallRaw = 1'b1;
                    incCnt   = 1'b1;
                end
            end
            default: begin
                stateNext = LSU_IDLE;
            end
        endcase
    end

    // Wait counter: restarts on every entry to REQ/RESP, counts stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (clearCnt) begin
            waitCnt <= '0;
        end else if (incCnt) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // MEM/WB register: real instruction on completion, otherwise a bubble
    // that carries only the bus-error flag when the access was abandoned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else if (complete) begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= (isLoad & ~misaligned) ? alignedData : 32'b0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM & ~misaligned;
            ResultSrcW <= ResultSrcM;
            MisalignW  <= misaligned;
            BusErrW    <= 1'b0;
        end else begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= timedOut;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed cases with literal expectations plus
// randomized instructions against a transaction-level model of the stage.
module tb_mem_stage_lsu;

    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [3:0]  DBe;
    logic [31:0] DWData;
    logic        DGnt;
    logic        DRValid;
    logic [31:0] DRData;
    logic        StallM;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        MisalignW;
    logic        BusErrW;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic        mis;
        logic        berr;
    } wres_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        int          g;
        int          r;
        bit          stray;
    } instr_t;

    int          tests = 0;
    int          fails = 0;
    bit          checkEn = 0;
    logic        expReq;
    logic        expStall;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expWData;
    logic [31:0] expAddr;
    wres_t       expWCur;
    wres_t       expWNext;
    int          obsStall = 0;
    int          obsReq = 0;
    int          prevStall = 0;
    int          prevReq = 0;
    logic [3:0]  obsBe = '0;
    logic [3:0]  prevBe = '0;
    logic [31:0] obsWData = '0;
    logic [31:0] prevWData = '0;

    mem_stage_lsu #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .PCPlus4M  (PCPlus4M),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .ResultSrcM(ResultSrcM),
        .Funct3M   (Funct3M),
        .DReq      (DReq),
        .DWe       (DWe),
        .DAddr     (DAddr),
        .DBe       (DBe),
        .DWData    (DWData),
        .DGnt      (DGnt),
        .DRValid   (DRValid),
        .DRData    (DRData),
        .StallM    (StallM),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .PCPlus4W  (PCPlus4W),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ResultSrcW(ResultSrcW),
        .MisalignW (MisalignW),
        .BusErrW   (BusErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access width in bytes for a funct3 code.
    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // Value a load must return, from byte arithmetic on the bus word.
    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd5: v = v % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    // Transaction plan: last cycle of the instruction, last cycle with a
    // request, and the MEM/WB contents captured at the end of that last cycle.
    function automatic void planAccess(input instr_t ins, output int endCyc,
                                       output int reqLast, output wres_t fin);
        bit isSt, isLd, acc, mis, done;
        int sz;
        isSt = ins.mw;
        isLd = !ins.mw && (ins.rs == 2'b01);
        acc  = isSt || isLd;
        sz   = sizeOf(ins.f3);
        mis  = acc && ((ins.alu % sz) != 0);
        fin  = '0;
        done = 1'b1;
        if (!acc || mis) begin
            endCyc  = 0;
            reqLast = -1;
        end else begin
            reqLast = (ins.g < TMO) ? ins.g : TMO;
            if (ins.g > TMO) begin
                endCyc = TMO;
                done   = 1'b0;
            end else if (isSt) begin
                endCyc = ins.g;
            end else if (ins.r > TMO) begin
                endCyc = ins.g + TMO;
                done   = 1'b0;
            end else begin
                endCyc = ins.g + ins.r;
            end
        end
        if (done) begin
            fin.alu   = ins.alu;
            fin.pc4   = ins.pc4;
            fin.rd    = ins.rd;
            fin.rs    = ins.rs;
            fin.rw    = ins.rw && !mis;
            fin.mis   = mis;
            fin.rdata = (isLd && !mis) ? modelLoad(ins.rdata, ins.alu[1:0], ins.f3) : 32'd0;
        end else begin
            fin.berr = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model's expectations.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("DReq", 32'(DReq), 32'(expReq));
            checkOutput("StallM", 32'(StallM), 32'(expStall));
            if (expReq) begin
                checkOutput("DAddr", DAddr, expAddr);
                checkOutput("DWe", 32'(DWe), 32'(expWe));
                checkOutput("DBe", 32'(DBe), 32'(expBe));
                checkOutput("DWData", DWData, expWData);
            end
            checkOutput("ALUResultW", ALUResultW, expWCur.alu);
            checkOutput("ReadDataW", ReadDataW, expWCur.rdata);
            checkOutput("PCPlus4W", PCPlus4W, expWCur.pc4);
            checkOutput("RdW", 32'(RdW), 32'(expWCur.rd));
            checkOutput("RegWriteW", 32'(RegWriteW), 32'(expWCur.rw));
            checkOutput("ResultSrcW", 32'(ResultSrcW), 32'(expWCur.rs));
            checkOutput("MisalignW", 32'(MisalignW), 32'(expWCur.mis));
            checkOutput("BusErrW", 32'(BusErrW), 32'(expWCur.berr));
            if (StallM) obsStall++;
            if (DReq) begin
                obsReq++;
                obsBe    = DBe;
                obsWData = DWData;
            end
        end
    end

    task automatic driveZero();
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = '0; Funct3M = '0;
        DGnt = 1'b0; DRValid = 1'b0; DRData = '0;
    endtask

    // Presents one EX/MEM entry and plays the bus side for it; abortAt >= 0
    // asserts reset in that cycle and abandons the instruction.
    task automatic applyStimulus(input instr_t ins, input int abortAt);
        int    endCyc;
        int    reqLast;
        int    sz;
        wres_t fin;
        bit    isLd;
        bit    acc;
        planAccess(ins, endCyc, reqLast, fin);
        isLd = !ins.mw && (ins.rs == 2'b01);
        acc  = ins.mw || isLd;
        sz   = sizeOf(ins.f3);
        for (int c = 0; c <= endCyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                prevStall = obsStall; prevReq = obsReq; prevBe = obsBe; prevWData = obsWData;
                obsStall = 0; obsReq = 0;
            end
            expWCur    = expWNext;
            ALUResultM = ins.alu;
            WriteDataM = ins.wd;
            PCPlus4M   = ins.pc4;
            RdM        = ins.rd;
            RegWriteM  = ins.rw;
            MemWriteM  = ins.mw;
            ResultSrcM = ins.rs;
            Funct3M    = ins.f3;
            DGnt       = (c == ins.g) && (c <= reqLast);
            DRValid    = (isLd && reqLast >= 0 && ins.g <= TMO && ins.r <= TMO && c == ins.g + ins.r)
                         || (!acc && ins.stray);
            DRData     = DRValid ? ins.rdata : $urandom;
            expReq     = (c <= reqLast);
            expStall   = (c < endCyc);
            expAddr    = ins.alu & 32'hFFFF_FFFC;
            expWe      = ins.mw;
            if (sz == 1) begin
                expBe    = 4'(1 << ins.alu[1:0]);
                expWData = 32'(ins.wd[7:0]) * 32'h0101_0101;
            end else if (sz == 2) begin
                expBe    = 4'(3 << ins.alu[1:0]);
                expWData = 32'(ins.wd[15:0]) * 32'h0001_0001;
            end else begin
                expBe    = 4'hF;
                expWData = ins.wd;
            end
            expWNext = (c == endCyc) ? fin : '0;
            if (c == abortAt) begin
                reset = 1'b0;
                driveZero();
                expReq = 1'b0; expStall = 1'b0; expWCur = '0; expWNext = '0;
                break;
            end
        end
    endtask

    function automatic instr_t makeNop();
        instr_t n;
        n.alu = $urandom; n.wd = $urandom; n.pc4 = $urandom; n.rdata = $urandom;
        n.rd = 5'($urandom); n.rw = 1'b1; n.mw = 1'b0; n.rs = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        n.f3 = 3'($urandom); n.g = 0; n.r = 1; n.stray = 1'b0;
        return n;
    endfunction

    function automatic instr_t makeRandom();
        instr_t n;
        int kind;
        int p;
        n = makeNop();
        kind = $urandom_range(0, 9);
        if ($urandom_range(0, 9) < 6) n.alu[1:0] = 2'b00;
        n.rw = 1'($urandom);
        if (kind >= 7) begin
            n.mw = 1'b1;
            n.rs = 2'($urandom);
        end else if (kind >= 3) begin
            n.rs = 2'b01;
        end else begin
            n.stray = ($urandom_range(0, 3) == 0);
        end
        p = $urandom_range(0, 19);
        n.g = (p < 14) ? $urandom_range(0, 3) : ((p < 18) ? $urandom_range(0, TMO + 2) : NEVER);
        p = $urandom_range(0, 19);
        n.r = (p < 15) ? $urandom_range(1, 3) : ((p < 19) ? $urandom_range(1, TMO + 2) : NEVER);
        return n;
    endfunction

    initial begin
        instr_t ins;
        instr_t nop2;

        reset = 1'b0;
        driveZero();
        expReq = 1'b0; expStall = 1'b0; expWe = 1'b0; expBe = '0; expWData = '0; expAddr = '0;
        expWCur = '0; expWNext = '0;
        checkEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero-wait word store.
        ins = makeNop();
        ins.alu = 32'h0000_0100; ins.wd = 32'hDEAD_BEEF; ins.mw = 1'b1; ins.rs = 2'b00;
        ins.rw = 1'b0; ins.f3 = 3'b010; ins.g = 0;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("sw stall cycles", 32'(prevStall), 32'd0);
        checkOutput("sw DBe", 32'(prevBe), 32'h0000_000F);
        checkOutput("sw RegWriteW", 32'(RegWriteW), 32'd0);

        // Signed byte load from the top lane with one RESP wait cycle.
        ins = makeNop();
        ins.alu = 32'h0000_0103; ins.rs = 2'b01; ins.f3 = 3'b000; ins.rd = 5'd5;
        ins.g = 0; ins.r = 2; ins.rdata = 32'h80FF_FFFF;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("lb stall cycles", 32'(prevStall), 32'd2);
        checkOutput("lb ReadDataW", ReadDataW, 32'hFFFF_FF80);

        // Unsigned upper halfword load.
        ins = makeNop();
        ins.alu = 32'h0000_0102; ins.rs = 2'b01; ins.f3 = 3'b101; ins.g = 1; ins.r = 1;
        ins.rdata = 32'h8001_0000;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("lhu ReadDataW", ReadDataW, 32'h0000_8001);

        // Byte store into lane 1.
        ins = makeNop();
        ins.alu = 32'h0000_0101; ins.wd = 32'h0000_005A; ins.mw = 1'b1; ins.rs = 2'b00;
        ins.f3 = 3'b000; ins.g = 0;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("sb DBe", 32'(prevBe), 32'h0000_0002);
        checkOutput("sb DWData", prevWData, 32'h5A5A_5A5A);

        // Misaligned word load is suppressed without touching the bus.
        ins = makeNop();
        ins.alu = 32'h0000_0102; ins.rs = 2'b01; ins.f3 = 3'b010; ins.rw = 1'b1;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("lw misaligned requests", 32'(prevReq), 32'd0);
        checkOutput("lw misaligned stalls", 32'(prevStall), 32'd0);
        checkOutput("lw MisalignW", 32'(MisalignW), 32'd1);
        checkOutput("lw RegWriteW", 32'(RegWriteW), 32'd0);
        applyStimulus(makeNop(), -1);
        checkOutput("MisalignW one cycle", 32'(MisalignW), 32'd0);

        // Load that is never granted times out.
        ins = makeNop();
        ins.alu = 32'h0000_0200; ins.rs = 2'b01; ins.f3 = 3'b010; ins.g = NEVER;
        applyStimulus(ins, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("timeout stall cycles", 32'(prevStall), 32'd16);
        checkOutput("timeout BusErrW", 32'(BusErrW), 32'd1);
        checkOutput("timeout RegWriteW", 32'(RegWriteW), 32'd0);

        // Reset in the middle of RESP, then a stray DRValid must be ignored.
        ins = makeNop();
        ins.alu = 32'h0000_0300; ins.rs = 2'b01; ins.f3 = 3'b010; ins.rd = 5'd9;
        ins.g = 0; ins.r = 6;
        applyStimulus(ins, 3);
        @(posedge clk);
        #1;
        checkOutput("reset ALUResultW", ALUResultW, 32'd0);
        checkOutput("reset RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("reset DReq", 32'(DReq), 32'd0);
        reset = 1'b1;
        nop2 = makeNop();
        nop2.alu = 32'h1234_5678; nop2.rd = 5'd17; nop2.rs = 2'b00; nop2.stray = 1'b1;
        applyStimulus(nop2, -1);
        applyStimulus(makeNop(), -1);
        checkOutput("stray ReadDataW", ReadDataW, 32'd0);
        checkOutput("stray ALUResultW", ALUResultW, 32'h1234_5678);
        checkOutput("stray RdW", 32'(RdW), 32'd17);
        checkOutput("stray stall cycles", 32'(prevStall), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            applyStimulus(makeRandom(), -1);
        end
        applyStimulus(makeNop(), -1);
        @(negedge clk);
        #1;
        checkEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
